// File: rtl/pmem_burst_responder_if.sv
// Bus bundle between the cacheline adaptor (master) and the burst responder (slave).
interface pmem_burst_responder_if;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [63:0] pmem_wdata;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;
  logic        pmem_err;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp, pmem_err
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp, pmem_err
  );
endinterface

// File: rtl/pmem_burst_responder.sv
// Physical-memory responder: programmable latency, then 4 x 64-bit beats per line.
// Optional protocol checker enabled by defining PMEM_PROTOCOL_CHECK_EN.
//
// state   | meaning
// IDLE    | waiting for a read/write request
// WAIT    | latency countdown after acceptance
// RBURST  | driving 4 read beats
// WBURST  | committing 4 write beats
// TURN    | one dead cycle, requests ignored
module pmem_burst_responder #(
  parameter int LATENCY = 10,
  parameter int IDX_W   = 8
) (
  input logic clk,
  input logic rst,
  pmem_burst_responder_if.slave pmem
);

  localparam int LAT_W = (LATENCY <= 1) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RBURST,
    S_WBURST,
    S_TURN
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_idx;
  logic               r_op_wr;
  logic [1:0]         r_beat;
  logic [LAT_W-1:0]   r_lat;
  logic [63:0]        r_rdata;
  logic               w_resp;
  logic               w_req;
  logic [IDX_W-1:0]   w_req_idx;
  logic [IDX_W-1:0]   w_rd_idx;
  logic [1:0]         w_rd_beat;
  logic [63:0]        r_mem [2**(IDX_W+2)];

  assign w_req     = pmem.pmem_read | pmem.pmem_write;
  assign w_req_idx = pmem.pmem_address[IDX_W+4:5];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (LATENCY == 0) w_next = pmem.pmem_read ? S_RBURST : S_WBURST;
          else              w_next = S_WAIT;
        end
      end
      S_WAIT:   if (r_lat == LAT_W'(1)) w_next = r_op_wr ? S_WBURST : S_RBURST;
      S_RBURST: if (r_beat == 2'd3) w_next = S_TURN;
      S_WBURST: if (r_beat == 2'd3) w_next = S_TURN;
      S_TURN:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_resp = (r_state == S_RBURST) || (r_state == S_WBURST);
  end

  // Read data is fetched one cycle ahead so it is registered yet aligned with resp.
  assign w_rd_idx  = (r_state == S_IDLE) ? w_req_idx : r_idx;
  assign w_rd_beat = (r_state == S_RBURST) ? r_beat + 2'd1 : 2'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_op_wr <= 1'b0;
      r_beat  <= 2'd0;
      r_lat   <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == S_IDLE && w_req) begin
        r_idx   <= w_req_idx;
        r_op_wr <= ~pmem.pmem_read;
        r_lat   <= LAT_W'(LATENCY);
      end else if (r_state == S_WAIT) begin
        r_lat <= r_lat - LAT_W'(1);
      end
      if (w_resp) r_beat <= r_beat + 2'd1;
      r_rdata <= (w_next == S_RBURST) ? r_mem[{w_rd_idx, w_rd_beat}] : 64'd0;
    end
  end

  // Line store is never reset; an async reset parks the FSM so no further beats commit.
  always_ff @(posedge clk) begin
    if (r_state == S_WBURST) r_mem[{r_idx, r_beat}] <= pmem.pmem_wdata;
  end

  assign pmem.pmem_resp  = w_resp;
  assign pmem.pmem_rdata = r_rdata;

`ifdef PMEM_PROTOCOL_CHECK_EN
  logic [31:0] r_addr;
  logic        r_err;
  logic        w_active;
  logic        w_viol;

  assign w_active = (r_state == S_WAIT) || (r_state == S_RBURST) || (r_state == S_WBURST);
  assign w_viol   = (pmem.pmem_read & pmem.pmem_write)
                  | (w_active & w_req & (pmem.pmem_address != r_addr))
                  | (w_active & (r_op_wr ? ~pmem.pmem_write : ~pmem.pmem_read))
                  | (w_active & (r_op_wr ? pmem.pmem_read : pmem.pmem_write));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_req) r_addr <= pmem.pmem_address;
      r_err <= r_err | w_viol;
    end
  end

  assign pmem.pmem_err = r_err;
`else
  assign pmem.pmem_err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Bench for pmem_burst_responder: LATENCY=10 and LATENCY=0 instances against a line-level model.
module tb_pmem_burst_responder;

`ifdef PMEM_PROTOCOL_CHECK_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        s_read, s_write;
  logic [31:0] s_addr;
  logic [63:0] s_wdata;
  logic        o_resp, o_err;
  logic [63:0] o_rdata;

  int checks   = 0;
  int failures = 0;

  logic [255:0] model [2][256];
  bit           valid [2][256];

  pmem_burst_responder_if bus0 ();
  pmem_burst_responder_if bus1 ();

  assign bus0.pmem_read    = ~sel & s_read;
  assign bus0.pmem_write   = ~sel & s_write;
  assign bus0.pmem_address = s_addr;
  assign bus0.pmem_wdata   = s_wdata;
  assign bus1.pmem_read    = sel & s_read;
  assign bus1.pmem_write   = sel & s_write;
  assign bus1.pmem_address = s_addr;
  assign bus1.pmem_wdata   = s_wdata;

  assign o_resp  = sel ? bus1.pmem_resp  : bus0.pmem_resp;
  assign o_rdata = sel ? bus1.pmem_rdata : bus0.pmem_rdata;
  assign o_err   = sel ? bus1.pmem_err   : bus0.pmem_err;

  pmem_burst_responder #(.LATENCY(10), .IDX_W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .pmem (bus0)
  );

  pmem_burst_responder #(.LATENCY(0), .IDX_W(8)) dut0 (
    .clk  (clk),
    .rst  (rst),
    .pmem (bus1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One host transaction starting in the current cycle (N). off=1 when N is a TURN cycle.
  task automatic run_txn(input logic s, input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [255:0] wline, input int off, input int abort_at,
                         input logic glitch, input logic keep);
    int           lat;
    int           idx;
    int           beat;
    int           first;
    logic         exp_resp;
    logic         prev_resp;
    logic [255:0] exp_line;
    lat       = s ? 0 : 10;
    idx       = int'((addr >> 5) & 32'hFF);
    exp_line  = model[s][idx];
    first     = off + lat + 1;
    beat      = 0;
    prev_resp = 1'b0;
    sel = s; s_read = rd; s_write = wr; s_addr = addr; s_wdata = wline[63:0];
    for (int c = 1; c <= first + 4; c++) begin
      @(posedge clk); #1;
      if (prev_resp) begin
        beat++;
        if (beat < 4) s_wdata = wline[beat*64 +: 64];
      end
      exp_resp = (c >= first) && (c <= first + 3);
      chk("resp", {63'd0, o_resp}, {63'd0, exp_resp});
      if (exp_resp && rd) chk("rdata", o_rdata, exp_line[(c-first)*64 +: 64]);
      else if (!exp_resp) chk("rdata_idle", o_rdata, 64'd0);
      if (c == 1 && rd && wr) chk("err_both", {63'd0, o_err}, {63'd0, CHK_EN});
      prev_resp = exp_resp;
      if (glitch && c == off + 2) s_addr = addr ^ 32'h0000_0100;
      if (abort_at > 0 && c == first + abort_at) begin
        rst = 1'b1; #1;
        chk("resp_abort", {63'd0, o_resp}, 64'd0);
        chk("rdata_abort", o_rdata, 64'd0);
        for (int k = 0; k < abort_at; k++) model[s][idx][k*64 +: 64] = wline[k*64 +: 64];
        s_read = 1'b0; s_write = 1'b0;
        return;
      end
    end
    if (wr && !rd) begin
      model[s][idx] = wline;
      valid[s][idx] = 1'b1;
    end
    s_addr = addr;
    if (!keep) begin
      s_read = 1'b0; s_write = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  initial begin
    logic [255:0] line_a, line_b, line_c, line_d;
    logic [31:0]  addr;
    logic         s, rd;
    int           idx;
    rst = 1'b1; sel = 1'b0; s_read = 1'b0; s_write = 1'b0; s_addr = '0; s_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      sel = i[0]; #1;
      chk("rst_resp", {63'd0, o_resp}, 64'd0);
      chk("rst_rdata", o_rdata, 64'd0);
      chk("rst_err", {63'd0, o_err}, 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Write then read, LATENCY=10
    line_a = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
    run_txn(1'b0, 1'b0, 1'b1, 32'h0000_0040, line_a, 0, 0, 1'b0, 1'b0);
    run_txn(1'b0, 1'b1, 1'b0, 32'h0000_0040, '0, 0, 0, 1'b0, 1'b0);

    // LATENCY=0, read held-over request right after TURN
    run_txn(1'b1, 1'b0, 1'b1, 32'h0000_0080, rnd_line(), 0, 0, 1'b0, 1'b1);
    run_txn(1'b1, 1'b1, 1'b0, 32'h0000_0080, '0, 1, 0, 1'b0, 1'b0);

    // Aliasing and ignored low bits
    run_txn(1'b0, 1'b0, 1'b1, 32'h0000_2000, rnd_line(), 0, 0, 1'b0, 1'b0);
    run_txn(1'b0, 1'b1, 1'b0, 32'h0000_0000, '0, 0, 0, 1'b0, 1'b0);
    run_txn(1'b0, 1'b1, 1'b0, 32'h0000_001F, '0, 0, 0, 1'b0, 1'b0);

    // Simultaneous read and write: read wins, line untouched
    line_b = rnd_line();
    run_txn(1'b0, 1'b0, 1'b1, 32'h0000_0060, rnd_line(), 0, 0, 1'b0, 1'b0);
    run_txn(1'b0, 1'b1, 1'b1, 32'h0000_0060, line_b, 0, 0, 1'b0, 1'b0);
    run_txn(1'b0, 1'b1, 1'b0, 32'h0000_0060, '0, 0, 0, 1'b0, 1'b0);

    // Address changed during WAIT: data from latched line
    run_txn(1'b0, 1'b1, 1'b0, 32'h0000_0040, '0, 0, 0, 1'b1, 1'b0);
    chk("err_sticky", {63'd0, o_err}, {63'd0, CHK_EN});

    // Reset after beat 1 of a write over D0..D3
    line_d = rnd_line();
    line_c = rnd_line();
    run_txn(1'b0, 1'b0, 1'b1, 32'h0000_00A0, line_d, 0, 0, 1'b0, 1'b0);
    run_txn(1'b0, 1'b0, 1'b1, 32'h0000_00A0, line_c, 0, 2, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("err_cleared", {63'd0, o_err}, 64'd0);
    @(posedge clk); #1;
    chk("resp_after_rst", {63'd0, o_resp}, 64'd0);
    run_txn(1'b0, 1'b1, 1'b0, 32'h0000_00A0, '0, 0, 0, 1'b0, 1'b0);

    // Randomized traffic on a few lines with random aliasing/low bits
    for (int i = 0; i < 16; i++) begin
      s    = 1'($urandom_range(0, 1));
      idx  = $urandom_range(0, 7);
      addr = ($urandom & 32'hFFFF_E01F) | (32'(idx) << 5);
      rd   = valid[s][idx] ? 1'($urandom_range(0, 1)) : 1'b0;
      run_txn(s, rd, ~rd, addr, rnd_line(), 0, 0, 1'b0, 1'b0);
    end
    chk("err_clean_traffic", {63'd0, o_err}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
